// File: rtl/regfile_pkg.sv
// Shared definitions for the clearable multi-read-port register file:
// sweep FSM encoding, read-port limit and depth helper.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } rf_state_e;

  localparam int NUM_RD_MAX = 4;

  function automatic int depth_of(input int a_width);
    return 1 << a_width;
  endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear-sweep sequencer: walks every address once after reset or a clr pulse,
// restarting from address 0 whenever clr is seen.
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int A_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  output logic               busy,
  output logic               sweep_we,
  output logic [A_WIDTH-1:0] sweep_addr,
  output rf_state_e          state_dbg
);

  localparam logic [A_WIDTH-1:0] LAST_ADDR = '1;

  rf_state_e          state_q, state_d;
  logic [A_WIDTH-1:0] ptr_q, ptr_d;
  logic               busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      CLEAR: begin
        if (clr) begin
          ptr_d = '0;
        end else if (ptr_q == LAST_ADDR) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase
    // busy is registered so it tracks the state the flops are about to hold
    busy_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  assign busy       = busy_q;
  assign sweep_we   = (state_q == CLEAR);
  assign sweep_addr = ptr_q;
  assign state_dbg  = state_q;

endmodule

// File: rtl/regfile_mp_clr.sv
// Register file with one write port, NUM_RD read ports, a hardware clear sweep,
// selectable write-first/read-first bypass and optional registered reads.
module regfile_mp_clr
  import regfile_pkg::*;
#(
  parameter int                  D_WIDTH  = 8,
  parameter int                  A_WIDTH  = 4,
  parameter int                  NUM_RD   = 2,
  parameter int                  RD_REG   = 0,
  parameter int                  BYPASS   = 1,
  parameter logic [D_WIDTH-1:0]  INIT_VAL = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  output logic                        busy,
  input  logic                        wren,
  input  logic [A_WIDTH-1:0]          waddr,
  input  logic [D_WIDTH-1:0]          wdata,
  output logic                        wr_drop,
  input  logic [NUM_RD*A_WIDTH-1:0]   raddr,
  output logic [NUM_RD*D_WIDTH-1:0]   rdata
);

  localparam int DEPTH = depth_of(A_WIDTH);

  if (NUM_RD < 1 || NUM_RD > NUM_RD_MAX) begin : g_bad_num_rd
    $error("regfile_mp_clr: NUM_RD=%0d outside 1..%0d", NUM_RD, NUM_RD_MAX);
  end

  logic               sweep_we;
  logic [A_WIDTH-1:0] sweep_addr;
  rf_state_e          seq_state;

  regfile_clr_seq #(
    .A_WIDTH (A_WIDTH)
  ) u_clr_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .busy       (busy),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr),
    .state_dbg  (seq_state)
  );

  // A user write only lands in IDLE and never alongside a clr request
  logic user_we;
  assign user_we = (seq_state == IDLE) && wren && !clr;

  logic               we_d;
  logic [A_WIDTH-1:0] wa_d;
  logic [D_WIDTH-1:0] wd_d;
  logic               wr_drop_q, wr_drop_d;

  always_comb begin
    we_d      = user_we;
    wa_d      = waddr;
    wd_d      = wdata;
    wr_drop_d = wren && ((seq_state == CLEAR) || clr);
    if (sweep_we) begin
      we_d = 1'b1;
      wa_d = sweep_addr;
      wd_d = INIT_VAL;
    end
  end

  logic [D_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_d) begin
      mem_q[wa_d] <= wd_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_drop_q <= 1'b0;
    end else begin
      wr_drop_q <= wr_drop_d;
    end
  end

  assign wr_drop = wr_drop_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [A_WIDTH-1:0] rd_addr;
    logic [D_WIDTH-1:0] sel_d;

    assign rd_addr = raddr[i*A_WIDTH +: A_WIDTH];

    // Array contents are undefined until the sweep finishes, so mask them while busy
    always_comb begin
      sel_d = mem_q[rd_addr];
      if (busy) begin
        sel_d = INIT_VAL;
      end else if ((BYPASS != 0) && user_we && (rd_addr == waddr)) begin
        sel_d = wdata;
      end
    end

    if (RD_REG != 0) begin : g_reg
      logic [D_WIDTH-1:0] rd_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_q <= '0;
        end else begin
          rd_q <= sel_d;
        end
      end
      assign rdata[i*D_WIDTH +: D_WIDTH] = rd_q;
    end else begin : g_comb
      assign rdata[i*D_WIDTH +: D_WIDTH] = sel_d;
    end
  end

endmodule

// File: tb/tb_regfile_mp_clr.sv
// Bench for regfile_mp_clr: four configurations (comb/registered x write-first/read-first)
// share one stimulus stream and one behavioural model of the storage and sweep.
module tb_regfile_mp_clr;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int NR = 2;
  localparam int DEPTH = 16;
  localparam logic [DW-1:0] INIT = 8'hA5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              clr;
  logic              wren;
  logic [AW-1:0]     waddr;
  logic [DW-1:0]     wdata;
  logic [NR*AW-1:0]  raddr;

  logic busy_a, busy_b, busy_c, busy_d;
  logic drop_a, drop_b, drop_c, drop_d;
  logic [NR*DW-1:0] rd_a, rd_b, rd_c, rd_d;

  regfile_mp_clr #(.D_WIDTH(DW), .A_WIDTH(AW), .NUM_RD(NR), .RD_REG(0), .BYPASS(1), .INIT_VAL(INIT)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_a), .wren(wren), .waddr(waddr),
    .wdata(wdata), .wr_drop(drop_a), .raddr(raddr), .rdata(rd_a));
  regfile_mp_clr #(.D_WIDTH(DW), .A_WIDTH(AW), .NUM_RD(NR), .RD_REG(0), .BYPASS(0), .INIT_VAL(INIT)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_b), .wren(wren), .waddr(waddr),
    .wdata(wdata), .wr_drop(drop_b), .raddr(raddr), .rdata(rd_b));
  regfile_mp_clr #(.D_WIDTH(DW), .A_WIDTH(AW), .NUM_RD(NR), .RD_REG(1), .BYPASS(1), .INIT_VAL(INIT)) u_c (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_c), .wren(wren), .waddr(waddr),
    .wdata(wdata), .wr_drop(drop_c), .raddr(raddr), .rdata(rd_c));
  regfile_mp_clr #(.D_WIDTH(DW), .A_WIDTH(AW), .NUM_RD(NR), .RD_REG(1), .BYPASS(0), .INIT_VAL(INIT)) u_d (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_d), .wren(wren), .waddr(waddr),
    .wdata(wdata), .wr_drop(drop_d), .raddr(raddr), .rdata(rd_d));

  // ---------------- scoreboard bookkeeping ----------------
  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] prt(input logic [NR*DW-1:0] v, input int p);
    return v[p*DW +: DW];
  endfunction

  // ---------------- behavioural model ----------------
  // Sweep modelled as "cycles left until storage is fully initialised"; since nothing
  // can observe or modify the array mid-sweep, the model initialises it all at once.
  logic [DW-1:0] m_mem[DEPTH];
  int            m_left;
  logic          m_drop;
  logic [DW-1:0] m_reg_c[NR];
  logic [DW-1:0] m_reg_d[NR];
  logic [DW-1:0] nxt_c[NR];
  logic [DW-1:0] nxt_d[NR];

  function automatic logic [DW-1:0] m_sel(input bit byp, input int p);
    logic [AW-1:0] ra;
    ra = raddr[p*AW +: AW];
    if (m_left > 0) return INIT;
    if (byp && wren && !clr && ra == waddr) return wdata;
    return m_mem[ra];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = DEPTH;
      m_drop = 1'b0;
      for (int k = 0; k < DEPTH; k++) m_mem[k] = INIT;
      for (int p = 0; p < NR; p++) begin
        m_reg_c[p] = '0;
        m_reg_d[p] = '0;
      end
    end else begin
      for (int p = 0; p < NR; p++) begin
        nxt_c[p] = m_sel(1'b1, p);
        nxt_d[p] = m_sel(1'b0, p);
      end
      m_drop = wren && (m_left > 0 || clr);
      if (m_left == 0 && wren && !clr) m_mem[waddr] = wdata;
      if (clr) begin
        m_left = DEPTH;
        for (int k = 0; k < DEPTH; k++) m_mem[k] = INIT;
      end else if (m_left > 0) begin
        m_left--;
      end
      for (int p = 0; p < NR; p++) begin
        m_reg_c[p] = nxt_c[p];
        m_reg_d[p] = nxt_d[p];
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy_a", busy_a, m_left > 0);
      chk("busy_c", busy_c, m_left > 0);
      chk("busy_bd", {busy_b, busy_d}, {2{m_left > 0}});
      chk("drop_a", drop_a, m_drop);
      chk("drop_bcd", {drop_b, drop_c, drop_d}, {3{m_drop}});
      for (int p = 0; p < NR; p++) begin
        chk($sformatf("rd_a[%0d]", p), prt(rd_a, p), m_sel(1'b1, p));
        chk($sformatf("rd_b[%0d]", p), prt(rd_b, p), m_sel(1'b0, p));
        chk($sformatf("rd_c[%0d]", p), prt(rd_c, p), m_reg_c[p]);
        chk($sformatf("rd_d[%0d]", p), prt(rd_d, p), m_reg_d[p]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input logic c, input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    @(posedge clk);
    #1;
    wren  = we;
    waddr = wa;
    wdata = wd;
    clr   = c;
    raddr = {r1, r0};
  endtask

  task automatic idle_inputs();
    wren  = 1'b0;
    waddr = '0;
    wdata = '0;
    clr   = 1'b0;
    raddr = '0;
  endtask

  // Counts consecutive busy cycles starting from the next sample point; bounded.
  task automatic count_busy(output int n);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (busy_a) n++;
      else break;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  int n;

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: sweep length after release and INIT contents everywhere
    rst_n = 1'b1;
    count_busy(n);
    chk("t1_busy_len", n, 16);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'hA5);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, '0, '0, 1'b0, AW'(i), AW'(15 - i));
      @(negedge clk);
      chk("t1_init_rd", prt(rd_a, 0), exp_q.pop_front());
    end

    // Test 2: write-first vs read-first, combinational and registered
    cyc(1'b1, 4'd5, 8'h3C, 1'b0, 4'd5, 4'd5);
    @(negedge clk);
    chk("t2_bypass_same", prt(rd_a, 0), 8'h3C);
    chk("t2_rdfirst_same", prt(rd_b, 0), 8'hA5);
    cyc(1'b0, '0, '0, 1'b0, 4'd5, 4'd5);
    @(negedge clk);
    chk("t2_rdfirst_next", prt(rd_b, 0), 8'h3C);
    chk("t2_reg_bypass", prt(rd_c, 0), 8'h3C);
    chk("t2_reg_rdfirst", prt(rd_d, 0), 8'hA5);
    cyc(1'b0, '0, '0, 1'b0, 4'd5, 4'd5);
    @(negedge clk);
    chk("t2_reg_rdfirst_late", prt(rd_d, 0), 8'h3C);

    // Test 3: registered read latency, two ports on one address
    cyc(1'b1, 4'd7, 8'h11, 1'b0, 4'd0, 4'd0);
    cyc(1'b0, '0, '0, 1'b0, 4'd7, 4'd7);
    cyc(1'b0, '0, '0, 1'b0, 4'd7, 4'd7);
    @(negedge clk);
    chk("t3_reg_p1", prt(rd_c, 1), 8'h11);
    chk("t3_reg_p0", prt(rd_c, 0), 8'h11);
    chk("t3_ports_equal", prt(rd_c, 0), prt(rd_c, 1));

    // Test 5: clr with a write, then a restart at sweep cycle 10
    cyc(1'b1, 4'd9, 8'h77, 1'b1, 4'd9, 4'd9);
    @(negedge clk);
    chk("t5_busy_clr_cycle", busy_a, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 4'd9, 4'd9);
    @(negedge clk);
    chk("t5_wr_drop", drop_a, 1'b1);
    chk("t5_busy_start", busy_a, 1'b1);
    count_busy(n);
    chk("t5_busy_len_rest", n, 15);   // first sweep cycle was sampled above
    cyc(1'b0, '0, '0, 1'b0, 4'd9, 4'd9);
    @(negedge clk);
    chk("t5_dropped_data", prt(rd_a, 0), 8'hA5);
    cyc(1'b0, '0, '0, 1'b1, '0, '0);
    for (int i = 0; i < 9; i++) cyc(1'b0, '0, '0, 1'b0, '0, '0);
    cyc(1'b0, '0, '0, 1'b1, '0, '0);
    cyc(1'b0, '0, '0, 1'b0, '0, '0);
    count_busy(n);
    chk("t5_restart_len", n, 16);

    // Test 6: async reset mid-sweep during a write burst
    cyc(1'b0, '0, '0, 1'b1, '0, '0);
    for (int i = 0; i < 4; i++) cyc(1'b1, AW'(i), 8'h40 + 8'(i), 1'b0, AW'(i), AW'(i));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_busy_async", busy_c, 1'b1);
    chk("t6_drop_async", drop_c, 1'b0);
    chk("t6_rdreg_async", rd_c, 16'h0000);
    chk("t6_rdreg_rdfirst_async", rd_d, 16'h0000);
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    count_busy(n);
    chk("t6_busy_len", n, 16);

    // Test 4: write during sweep cycle 3 is dropped
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b0, '0, '0, 1'b0, '0, '0);
    cyc(1'b1, 4'd2, 8'hFF, 1'b0, 4'd2, 4'd2);
    @(negedge clk);
    chk("t4_drop_before", drop_a, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 4'd2, 4'd2);
    @(negedge clk);
    chk("t4_drop_pulse", drop_a, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 4'd2, 4'd2);
    @(negedge clk);
    chk("t4_drop_after", drop_a, 1'b0);
    count_busy(n);
    chk("t4_busy_rest", n, 11);
    cyc(1'b0, '0, '0, 1'b0, 4'd2, 4'd2);
    @(negedge clk);
    chk("t4_addr2_init", prt(rd_a, 0), 8'hA5);
    chk("t4_addr2_init_b", prt(rd_b, 1), 8'hA5);

    // Random phase: writes, reads near the write address, occasional clr
    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] wa, r0, r1;
      wa = AW'($urandom_range(0, DEPTH - 1));
      r0 = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
      r1 = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
      cyc(1'($urandom_range(0, 1)), wa, 8'($urandom_range(0, 255)),
          1'($urandom_range(0, 63) == 0), r0, r1);
    end
    idle_inputs();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
